// File: rtl/jt12_eg_final_seq.sv
// Slot sequencer and shared-resource controller for the final EG attenuation stage.
// Optional build macro JT12_EG_SEQ_PEAK_EN adds peak_atten (per-frame minimum attenuation).
module jt12_eg_final_seq #(
    parameter int         SLOTS   = 24,
    parameter logic [9:0] ATT_RST = 10'h3FF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cfg_we,
    input  logic [4:0] cfg_slot,
    input  logic [6:0] cfg_tl,
    input  logic [1:0] cfg_ams,
    input  logic       cfg_amsen,
    input  logic [6:0] lfo_mod,
    input  logic [9:0] eg_pream,
    output logic [4:0] cur_slot,
    output logic [6:0] dp_tl,
    output logic [1:0] dp_ams,
    output logic       dp_amsen,
    output logic [6:0] dp_lfo_mod,
    output logic [9:0] dp_eg_pream,
    input  logic [9:0] dp_eg_limited,
    output logic [9:0] eg_out,
    output logic [4:0] eg_slot,
    output logic       eg_valid,
    output logic       zero,
    input  logic [4:0] rd_slot,
    output logic [9:0] rd_data
`ifdef JT12_EG_SEQ_PEAK_EN
    ,
    output logic [9:0] peak_atten
`endif
);

    localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);

    logic [4:0] r_slot;
    logic [6:0] r_lfo_latch;
    logic [6:0] r_tl    [SLOTS];
    logic [1:0] r_ams   [SLOTS];
    logic       r_amsen [SLOTS];
    logic [9:0] r_buf   [SLOTS];
    logic [9:0] r_eg_out;
    logic [4:0] r_eg_slot;
    logic       r_eg_valid;
    logic       r_zero;
    logic [9:0] r_rd_data;

    logic       w_last;
    logic       w_cfg_ok;
    logic       w_rd_ok;
    logic [4:0] w_slot_nxt;

    assign w_last     = (r_slot == LAST_SLOT);
    assign w_cfg_ok   = cfg_we && (cfg_slot <= LAST_SLOT);
    assign w_rd_ok    = (rd_slot <= LAST_SLOT);
    assign w_slot_nxt = w_last ? 5'd0 : r_slot + 5'd1;

    // Datapath is driven straight from the issued slot's configuration.
    assign cur_slot    = r_slot;
    assign dp_tl       = r_tl[r_slot];
    assign dp_ams      = r_ams[r_slot];
    assign dp_amsen    = r_amsen[r_slot];
    assign dp_lfo_mod  = r_lfo_latch;
    assign dp_eg_pream = eg_pream;

    assign eg_out   = r_eg_out;
    assign eg_slot  = r_eg_slot;
    assign eg_valid = r_eg_valid;
    assign zero     = r_zero;
    assign rd_data  = r_rd_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot      <= 5'd0;
            r_lfo_latch <= 7'd0;
        end else if (clk_en) begin
            r_slot <= w_slot_nxt;
            // AM value is frozen at the frame boundary so a whole frame shares it.
            if (w_last)
                r_lfo_latch <= lfo_mod;
        end
    end

    // A same-cycle write to the issued slot lands after this cycle's datapath read.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++) begin
                r_tl[i]    <= 7'h7F;
                r_ams[i]   <= 2'd0;
                r_amsen[i] <= 1'b0;
            end
        end else if (w_cfg_ok) begin
            r_tl[cfg_slot]    <= cfg_tl;
            r_ams[cfg_slot]   <= cfg_ams;
            r_amsen[cfg_slot] <= cfg_amsen;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_eg_out   <= ATT_RST;
            r_eg_slot  <= 5'd0;
            r_eg_valid <= 1'b0;
            r_zero     <= 1'b0;
        end else begin
            r_eg_valid <= clk_en;
            if (clk_en) begin
                r_eg_out  <= dp_eg_limited;
                r_eg_slot <= r_slot;
                r_zero    <= (r_slot == 5'd0);
            end
        end
    end

    // Readback samples the buffer before this edge's capture (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SLOTS; i++)
                r_buf[i] <= ATT_RST;
            r_rd_data <= ATT_RST;
        end else begin
            r_rd_data <= w_rd_ok ? r_buf[rd_slot] : ATT_RST;
            if (clk_en)
                r_buf[r_slot] <= dp_eg_limited;
        end
    end

`ifdef JT12_EG_SEQ_PEAK_EN
    logic [9:0] r_min;
    logic [9:0] r_peak;
    logic [9:0] w_min_nxt;

    assign w_min_nxt  = (dp_eg_limited < r_min) ? dp_eg_limited : r_min;
    assign peak_atten = r_peak;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_min  <= 10'h3FF;
            r_peak <= 10'h3FF;
        end else if (clk_en) begin
            if (w_last) begin
                r_peak <= w_min_nxt;
                r_min  <= 10'h3FF;
            end else begin
                r_min <= w_min_nxt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jt12_eg_final_seq.sv
// Self-checking bench for jt12_eg_final_seq: a behavioural final-stage model plus a slot-level reference model.
module tb_jt12_eg_final_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       clk_en;
    logic       cfg_we;
    logic [4:0] cfg_slot;
    logic [6:0] cfg_tl;
    logic [1:0] cfg_ams;
    logic       cfg_amsen;
    logic [6:0] lfo_mod;
    logic [9:0] eg_pream;
    logic [4:0] cur_slot;
    logic [6:0] dp_tl;
    logic [1:0] dp_ams;
    logic       dp_amsen;
    logic [6:0] dp_lfo_mod;
    logic [9:0] dp_eg_pream;
    logic [9:0] dp_eg_limited;
    logic [9:0] eg_out;
    logic [4:0] eg_slot;
    logic       eg_valid;
    logic       zero;
    logic [4:0] rd_slot;
    logic [9:0] rd_data;
`ifdef JT12_EG_SEQ_PEAK_EN
    logic [9:0] peak_atten;
`endif

    int total = 0;
    int bad   = 0;

    jt12_eg_final_seq dut (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .cfg_we(cfg_we), .cfg_slot(cfg_slot), .cfg_tl(cfg_tl),
        .cfg_ams(cfg_ams), .cfg_amsen(cfg_amsen),
        .lfo_mod(lfo_mod), .eg_pream(eg_pream),
        .cur_slot(cur_slot), .dp_tl(dp_tl), .dp_ams(dp_ams),
        .dp_amsen(dp_amsen), .dp_lfo_mod(dp_lfo_mod),
        .dp_eg_pream(dp_eg_pream), .dp_eg_limited(dp_eg_limited),
        .eg_out(eg_out), .eg_slot(eg_slot), .eg_valid(eg_valid),
        .zero(zero), .rd_slot(rd_slot), .rd_data(rd_data)
`ifdef JT12_EG_SEQ_PEAK_EN
        , .peak_atten(peak_atten)
`endif
    );

    always #5 clk = ~clk;

    // Final attenuation arithmetic: EG + TL*8 + scaled AM, saturated to 10 bits.
    function automatic logic [9:0] final_stage(input logic [6:0] tl, input logic [1:0] ams,
                                               input logic amsen, input logic [6:0] lfo,
                                               input logic [9:0] eg);
        int inv, am, s;
        inv = lfo[6] ? (63 - int'(lfo[5:0])) : int'(lfo[5:0]);
        case (ams)
            2'd0: am = 0;
            2'd1: am = inv / 4;
            2'd2: am = inv;
            default: am = inv * 2;
        endcase
        if (!amsen) am = 0;
        s = int'(eg) + int'(tl) * 8 + am;
        return (s > 1023) ? 10'h3FF : 10'(s);
    endfunction

    always_comb dp_eg_limited = final_stage(dp_tl, dp_ams, dp_amsen, dp_lfo_mod, dp_eg_pream);

    int         m_slot;
    logic [6:0] m_latch;
    logic [6:0] m_tl    [24];
    logic [1:0] m_ams   [24];
    logic       m_amsen [24];
    logic [9:0] m_buf   [24];
    logic [9:0] m_eg;
    int         m_egslot;
    logic       m_valid;
    logic       m_zero;
    logic [9:0] m_rd;
    logic [9:0] m_min;
    logic [9:0] m_peak;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_slot = 0; m_latch = 7'd0;
        for (int i = 0; i < 24; i++) begin
            m_tl[i] = 7'h7F; m_ams[i] = 2'd0; m_amsen[i] = 1'b0; m_buf[i] = 10'h3FF;
        end
        m_eg = 10'h3FF; m_egslot = 0; m_valid = 1'b0; m_zero = 1'b0; m_rd = 10'h3FF;
        m_min = 10'h3FF; m_peak = 10'h3FF;
    endtask

    task automatic check_regs();
        chk("eg_out", eg_out, m_eg);
        chk("eg_slot", eg_slot, m_egslot);
        chk("eg_valid", eg_valid, m_valid);
        chk("zero", zero, m_zero);
        chk("rd_data", rd_data, m_rd);
`ifdef JT12_EG_SEQ_PEAK_EN
        chk("peak_atten", peak_atten, m_peak);
`endif
    endtask

    // One clock: check issue-side outputs, predict the edge, then check captured outputs.
    task automatic step();
        logic [9:0] lim;
        logic [9:0] n_rd;
        #1;
        chk("cur_slot", cur_slot, m_slot);
        chk("dp_tl", dp_tl, m_tl[m_slot]);
        chk("dp_ams", dp_ams, m_ams[m_slot]);
        chk("dp_amsen", dp_amsen, m_amsen[m_slot]);
        chk("dp_lfo_mod", dp_lfo_mod, m_latch);
        chk("dp_eg_pream", dp_eg_pream, eg_pream);
        lim  = final_stage(m_tl[m_slot], m_ams[m_slot], m_amsen[m_slot], m_latch, eg_pream);
        n_rd = (rd_slot < 24) ? m_buf[rd_slot] : 10'h3FF;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            m_rd    = n_rd;
            m_valid = clk_en;
            if (clk_en) begin
                m_eg = lim; m_egslot = m_slot; m_zero = (m_slot == 0); m_buf[m_slot] = lim;
                if (m_slot == 23) begin
                    m_peak = (lim < m_min) ? lim : m_min;
                    m_min  = 10'h3FF;
                    m_latch = lfo_mod;
                end else if (lim < m_min) begin
                    m_min = lim;
                end
                m_slot = (m_slot + 1) % 24;
            end
            if (cfg_we && cfg_slot < 24) begin
                m_tl[cfg_slot] = cfg_tl; m_ams[cfg_slot] = cfg_ams; m_amsen[cfg_slot] = cfg_amsen;
            end
        end
        check_regs();
    endtask

    task automatic cfg_write(input logic [4:0] s, input logic [6:0] tl, input logic [1:0] ams,
                             input logic amsen);
        clk_en = 1'b0; cfg_we = 1'b1; cfg_slot = s; cfg_tl = tl; cfg_ams = ams; cfg_amsen = amsen;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clk_en = 1'b0; cfg_we = 1'b0; cfg_slot = 5'd0; cfg_tl = 7'd0;
        cfg_ams = 2'd0; cfg_amsen = 1'b0; lfo_mod = 7'd0; eg_pream = 10'd0; rd_slot = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_regs();
        chk("rst_eg_out", eg_out, 10'h3FF);
        chk("rst_cur_slot", cur_slot, 5'd0);
        chk("rst_dp_tl", dp_tl, 7'h7F);
        rst = 1'b0;

        cfg_write(5'd3, 7'h10, 2'd0, 1'b0);
        cfg_write(5'd5, 7'h00, 2'd3, 1'b1);
        cfg_write(5'd7, 7'h40, 2'd0, 1'b0);
        cfg_write(5'd25, 7'h00, 2'd3, 1'b1);
        lfo_mod = 7'h45;

        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 24; s++) begin
                clk_en = 1'b1; cfg_we = 1'b0; rd_slot = 5'(m_slot);
                eg_pream = (m_slot == 3) ? 10'h020 : (m_slot == 2) ? 10'h3FF : 10'h000;
                if (f == 1 && m_slot == 7) begin
                    cfg_we = 1'b1; cfg_slot = 5'd7; cfg_tl = 7'h01; cfg_ams = 2'd0; cfg_amsen = 1'b0;
                end
                if (f == 1 && m_slot == 10) lfo_mod = 7'h00;
                step();
                if (m_egslot == 3) chk("tp_slot3", eg_out, 10'h0A0);
                if (m_egslot == 2) chk("tp_sat", eg_out, 10'h3FF);
                if (f == 1 && m_egslot == 5) chk("tp_am", eg_out, 10'h074);
                if (f == 2 && m_egslot == 5) chk("tp_am_next", eg_out, 10'h000);
                if (f == 1 && m_egslot == 7) chk("tp_coll_old", eg_out, 10'h200);
                if (f == 2 && m_egslot == 7) chk("tp_coll_new", eg_out, 10'h008);
            end
        end

        clk_en = 1'b0; cfg_we = 1'b0; rd_slot = 5'd3;
        step();
        step();
        chk("tp_rd3", rd_data, 10'h0A0);
        rd_slot = 5'd30;
        step();
        step();
        chk("tp_rd_oor", rd_data, 10'h3FF);

        clk_en = 1'b1;
        for (int i = 0; i < 40 && m_slot != 12; i++) step();
        chk("tp_at12", cur_slot, 5'd12);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("tp_rst_eg", eg_out, 10'h3FF);
        step();
        chk("tp_rst_zero", zero, 1'b1);

        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            clk_en    = ($urandom_range(0, 3) != 0);
            cfg_we    = ($urandom_range(0, 4) == 0);
            cfg_slot  = 5'($urandom_range(0, 31));
            cfg_tl    = 7'($urandom);
            cfg_ams   = 2'($urandom);
            cfg_amsen = 1'($urandom);
            lfo_mod   = 7'($urandom);
            eg_pream  = 10'($urandom);
            rd_slot   = 5'($urandom_range(0, 31));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
